pkt_scheduler: RTL and testbench

- Top-level sequencer for per-packet processing in the node.
- On each received packet, launches the cost-learning client, then the cluster-reinit client (only if requested), then the action-selection client, using en/done handshakes.
- Owns the single shared data-memory port and muxes it to whichever client is active.
- Latches packet fields so every client sees stable inputs for the whole run.

---
 rtl/pkt_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_pkt_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_scheduler.sv
// Per-packet sequencer: runs cost-learning, optional cluster-reinit and action-selection
// clients in turn and muxes the shared memory port to the active one. Optional: SCHED_STATS_EN.
module pkt_scheduler #(
  parameter int WORD_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [WORD_WIDTH-1:0] pkt_sourceID,
  input  logic [WORD_WIDTH-1:0] pkt_batteryStat,
  input  logic [WORD_WIDTH-1:0] pkt_value,
  input  logic [WORD_WIDTH-1:0] pkt_clusterID,
  output logic [WORD_WIDTH-1:0] fsourceID,
  output logic [WORD_WIDTH-1:0] fbatteryStat,
  output logic [WORD_WIDTH-1:0] fValue,
  output logic [WORD_WIDTH-1:0] fclusterID,
  output logic                  lc_en,
  output logic                  ri_en,
  output logic                  sa_en,
  input  logic                  lc_done,
  input  logic                  ri_done,
  input  logic                  sa_done,
  input  logic                  lc_reinit,
  input  logic [WORD_WIDTH-1:0] lc_address,
  input  logic [WORD_WIDTH-1:0] ri_address,
  input  logic [WORD_WIDTH-1:0] sa_address,
  input  logic                  lc_wr_en,
  input  logic                  ri_wr_en,
  input  logic                  sa_wr_en,
  input  logic [WORD_WIDTH-1:0] lc_data_out,
  input  logic [WORD_WIDTH-1:0] ri_data_out,
  input  logic [WORD_WIDTH-1:0] sa_data_out,
  output logic [WORD_WIDTH-1:0] mem_address,
  output logic                  mem_wr_en,
  output logic [WORD_WIDTH-1:0] mem_data_out,
  output logic                  done,
  output logic                  err,
  output logic                  reinit_taken,
  output logic [WORD_WIDTH-1:0] pkt_count,
  output logic [WORD_WIDTH-1:0] reinit_count
);

  typedef enum logic [2:0] {
    IDLE, LC_START, LC_WAIT, RI_START, RI_WAIT, SA_START, SA_WAIT, FINISH
  } state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_LC, OWN_RI, OWN_SA} owner_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  owner_t      owner;
  logic [15:0] wd_count;
  logic        wd_expired;

  assign pkt_ready  = (state == IDLE);
  assign wd_expired = (wd_count == WD_LAST);

  // Owner is set on the edge into each START so the client owns the port for START and WAIT.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      wd_count     <= '0;
      lc_en        <= 1'b0;
      ri_en        <= 1'b0;
      sa_en        <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      reinit_taken <= 1'b0;
      fsourceID    <= '0;
      fbatteryStat <= '0;
      fValue       <= '0;
      fclusterID   <= '0;
    end else begin
      lc_en <= 1'b0;
      ri_en <= 1'b0;
      sa_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_valid) begin
            fsourceID    <= pkt_sourceID;
            fbatteryStat <= pkt_batteryStat;
            fValue       <= pkt_value;
            fclusterID   <= pkt_clusterID;
            err          <= 1'b0;
            reinit_taken <= 1'b0;
            lc_en        <= 1'b1;
            owner        <= OWN_LC;
            wd_count     <= '0;
            state        <= LC_START;
          end
        end
        LC_START: begin
          wd_count <= '0;
          state    <= LC_WAIT;
        end
        LC_WAIT: begin
          if (lc_done) begin
            wd_count <= '0;
            if (lc_reinit) begin
              ri_en        <= 1'b1;
              owner        <= OWN_RI;
              reinit_taken <= 1'b1;
              state        <= RI_START;
            end else begin
              sa_en <= 1'b1;
              owner <= OWN_SA;
              state <= SA_START;
            end
          end else if (wd_expired) begin
            err   <= 1'b1;
            done  <= 1'b1;
            owner <= OWN_NONE;
            state <= FINISH;
          end else begin
            wd_count <= wd_count + 16'd1;
          end
        end
        RI_START: begin
          wd_count <= '0;
          state    <= RI_WAIT;
        end
        RI_WAIT: begin
          if (ri_done) begin
            wd_count <= '0;
            sa_en    <= 1'b1;
            owner    <= OWN_SA;
            state    <= SA_START;
          end else if (wd_expired) begin
            err   <= 1'b1;
            done  <= 1'b1;
            owner <= OWN_NONE;
            state <= FINISH;
          end else begin
            wd_count <= wd_count + 16'd1;
          end
        end
        SA_START: begin
          wd_count <= '0;
          state    <= SA_WAIT;
        end
        SA_WAIT: begin
          if (sa_done) begin
            done  <= 1'b1;
            owner <= OWN_NONE;
            state <= FINISH;
          end else if (wd_expired) begin
            err   <= 1'b1;
            done  <= 1'b1;
            owner <= OWN_NONE;
            state <= FINISH;
          end else begin
            wd_count <= wd_count + 16'd1;
          end
        end
        FINISH: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_address  = '0;
    mem_wr_en    = 1'b0;
    mem_data_out = '0;
    case (owner)
      OWN_LC: begin
        mem_address  = lc_address;
        mem_wr_en    = lc_wr_en;
        mem_data_out = lc_data_out;
      end
      OWN_RI: begin
        mem_address  = ri_address;
        mem_wr_en    = ri_wr_en;
        mem_data_out = ri_data_out;
      end
      OWN_SA: begin
        mem_address  = sa_address;
        mem_wr_en    = sa_wr_en;
        mem_data_out = sa_data_out;
      end
      default: begin
        mem_address  = '0;
        mem_wr_en    = 1'b0;
        mem_data_out = '0;
      end
    endcase
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clock) begin
    if (!nrst) begin
      pkt_count    <= '0;
      reinit_count <= '0;
    end else begin
      if (state == FINISH)   pkt_count    <= pkt_count + 1'b1;
      if (state == RI_START) reinit_count <= reinit_count + 1'b1;
    end
  end
`else
  assign pkt_count    = '0;
  assign reinit_count = '0;
`endif

endmodule

// File: tb/tb_pkt_scheduler.sv
// Directed bench for pkt_scheduler: mux vector table plus hand-written sequences for
// handshakes, watchdog, busy/back-to-back and mid-run reset.
module tb_pkt_scheduler;
  localparam int W = 16;

  logic         clock, nrst;
  logic         pkt_valid, pkt_ready;
  logic [W-1:0] pkt_sourceID, pkt_batteryStat, pkt_value, pkt_clusterID;
  logic [W-1:0] fsourceID, fbatteryStat, fValue, fclusterID;
  logic         lc_en, ri_en, sa_en, lc_done, ri_done, sa_done, lc_reinit;
  logic [W-1:0] lc_address, ri_address, sa_address;
  logic         lc_wr_en, ri_wr_en, sa_wr_en;
  logic [W-1:0] lc_data_out, ri_data_out, sa_data_out;
  logic [W-1:0] mem_address, mem_data_out;
  logic         mem_wr_en, done, err, reinit_taken;
  logic [W-1:0] pkt_count, reinit_count;

  pkt_scheduler #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .nrst(nrst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_sourceID(pkt_sourceID), .pkt_batteryStat(pkt_batteryStat),
    .pkt_value(pkt_value), .pkt_clusterID(pkt_clusterID),
    .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
    .fclusterID(fclusterID), .lc_en(lc_en), .ri_en(ri_en), .sa_en(sa_en),
    .lc_done(lc_done), .ri_done(ri_done), .sa_done(sa_done), .lc_reinit(lc_reinit),
    .lc_address(lc_address), .ri_address(ri_address), .sa_address(sa_address),
    .lc_wr_en(lc_wr_en), .ri_wr_en(ri_wr_en), .sa_wr_en(sa_wr_en),
    .lc_data_out(lc_data_out), .ri_data_out(ri_data_out), .sa_data_out(sa_data_out),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_data_out(mem_data_out),
    .done(done), .err(err), .reinit_taken(reinit_taken),
    .pkt_count(pkt_count), .reinit_count(reinit_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  int ri_en_seen = 0;
  int done_seen  = 0;
  always @(negedge clock) begin
    if (ri_en) ri_en_seen++;
    if (done)  done_seen++;
  end

  typedef struct {
    logic         stage;
    logic         lc_w; logic [W-1:0] lc_a; logic [W-1:0] lc_d;
    logic         ri_w; logic [W-1:0] ri_a; logic [W-1:0] ri_d;
    logic         sa_w; logic [W-1:0] sa_a; logic [W-1:0] sa_d;
    logic         exp_w; logic [W-1:0] exp_a; logic [W-1:0] exp_d;
  } vec_t;
  vec_t vecs[5];

  // driver tasks
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h required 0x%04h", name, act, exp);
  endtask

  function automatic logic get_sig(input int which);
    case (which)
      0: return lc_en;
      1: return ri_en;
      2: return sa_en;
      default: return done;
    endcase
  endfunction

  task automatic wait_high(input string name, input int which, input int limit);
    int k = 0;
    while (get_sig(which) !== 1'b1 && k < limit) begin
      cyc();
      k++;
    end
    check(name, {15'd0, get_sig(which)}, 16'd1);
  endtask

  task automatic offer_pkt(input logic [W-1:0] src, input logic [W-1:0] batt,
                           input logic [W-1:0] val, input logic [W-1:0] cl);
    pkt_valid       = 1'b1;
    pkt_sourceID    = src;
    pkt_batteryStat = batt;
    pkt_value       = val;
    pkt_clusterID   = cl;
  endtask

  task automatic clear_clients();
    lc_done = 0; ri_done = 0; sa_done = 0; lc_reinit = 0;
    lc_wr_en = 0; ri_wr_en = 0; sa_wr_en = 0;
    lc_address = '0; ri_address = '0; sa_address = '0;
    lc_data_out = '0; ri_data_out = '0; sa_data_out = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    lc_wr_en = v.lc_w; lc_address = v.lc_a; lc_data_out = v.lc_d;
    ri_wr_en = v.ri_w; ri_address = v.ri_a; ri_data_out = v.ri_d;
    sa_wr_en = v.sa_w; sa_address = v.sa_a; sa_data_out = v.sa_d;
  endtask

  int ri0, dn0, cur_stage;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h068A, 16'h00AB, 1'b1, 16'h0100, 16'h1111, 1'b0, 16'h0200, 16'h2222, 1'b1, 16'h068A, 16'h00AB};
    vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h3333, 1'b1, 16'h0100, 16'h1111, 1'b1, 16'h0200, 16'h2222, 1'b0, 16'h0010, 16'h3333};
    vecs[2] = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{1'b1, 1'b1, 16'h068A, 16'h00AB, 1'b1, 16'h0100, 16'h1111, 1'b1, 16'h0300, 16'h5A5A, 1'b1, 16'h0300, 16'h5A5A};
    vecs[4] = '{1'b1, 1'b1, 16'h068A, 16'h00AB, 1'b0, 16'h0100, 16'h1111, 1'b0, 16'h0301, 16'h0000, 1'b0, 16'h0301, 16'h0000};

    nrst = 0; pkt_valid = 0;
    pkt_sourceID = '0; pkt_batteryStat = '0; pkt_value = '0; pkt_clusterID = '0;
    clear_clients();
    cyc(); cyc(); cyc();
    check("rst_pkt_ready", {15'd0, pkt_ready}, 16'd1);
    check("rst_en", {13'd0, lc_en, ri_en, sa_en}, 16'd0);
    check("rst_done_err_rt", {13'd0, done, err, reinit_taken}, 16'd0);
    check("rst_fsourceID", fsourceID, 16'h0000);
    check("rst_mem", {15'd0, mem_wr_en} | mem_address | mem_data_out, 16'd0);
    nrst = 1;
    cyc();

    // normal packet, no reinit
    ri0 = ri_en_seen; dn0 = done_seen;
    offer_pkt(16'h0005, 16'h0064, 16'h0030, 16'h0002);
    cyc();
    check("t1_lc_en_latency", {15'd0, lc_en}, 16'd1);
    check("t1_busy_not_ready", {15'd0, pkt_ready}, 16'd0);
    check("t1_fsourceID", fsourceID, 16'h0005);
    check("t1_fValue", fValue, 16'h0030);
    check("t1_fbattery_fcluster", fbatteryStat ^ fclusterID, 16'h0066);
    pkt_valid = 0;
    cyc();
    check("t1_lc_en_one_cycle", {15'd0, lc_en}, 16'd0);
    cyc(); cyc();
    lc_done = 1; lc_reinit = 0;
    cyc();
    check("t1_sa_en_after_lc_done", {15'd0, sa_en}, 16'd1);
    lc_done = 0;
    cyc();
    check("t1_sa_en_one_cycle", {15'd0, sa_en}, 16'd0);
    sa_done = 1;
    cyc();
    check("t1_done", {15'd0, done}, 16'd1);
    check("t1_reinit_taken", {15'd0, reinit_taken}, 16'd0);
    sa_done = 0;
    cyc();
    check("t1_done_pulse_end", {15'd0, done}, 16'd0);
    check("t1_ready_after_finish", {15'd0, pkt_ready}, 16'd1);
    check("t1_ri_en_never", 16'(ri_en_seen - ri0), 16'd0);
    check("t1_done_once", 16'(done_seen - dn0), 16'd1);

    // reinit path
    offer_pkt(16'h0007, 16'h0010, 16'h0040, 16'h0003);
    cyc();
    pkt_valid = 0;
    cyc();
    lc_done = 1; lc_reinit = 1;
    cyc();
    check("t2_ri_en", {15'd0, ri_en}, 16'd1);
    check("t2_no_sa_en", {15'd0, sa_en}, 16'd0);
    check("t2_reinit_taken", {15'd0, reinit_taken}, 16'd1);
    lc_done = 0; lc_reinit = 0;
    cyc();
    ri_done = 1;
    cyc();
    check("t2_sa_en_after_ri", {15'd0, sa_en}, 16'd1);
    ri_done = 0;
    cyc();
    sa_done = 1;
    cyc();
    check("t2_done", {15'd0, done}, 16'd1);
    sa_done = 0;
    cyc();
    check("t2_reinit_taken_held", {15'd0, reinit_taken}, 16'd1);
`ifdef SCHED_STATS_EN
    check("t2_pkt_count", pkt_count, 16'd2);
    check("t2_reinit_count", reinit_count, 16'd1);
`else
    check("t2_pkt_count_tied", pkt_count, 16'd0);
    check("t2_reinit_count_tied", reinit_count, 16'd0);
`endif

    // memory mux isolation
    offer_pkt(16'h0009, 16'h0001, 16'h0002, 16'h0004);
    cyc();
    check("t3_accept_clears_rt", {15'd0, reinit_taken}, 16'd0);
    pkt_valid = 0;
    cyc();
    cur_stage = 0;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].stage == 1'b1 && cur_stage == 0) begin
        clear_clients();
        lc_done = 1; lc_wr_en = 1; lc_address = 16'h0042; lc_data_out = 16'h0077;
        #1;
        check("t3_write_with_done", {15'd0, mem_wr_en}, 16'd1);
        check("t3_write_with_done_addr", mem_address, 16'h0042);
        cyc();
        lc_done = 0;
        #1;
        check("t3_lc_write_after_handoff", {15'd0, mem_wr_en}, 16'd0);
        cyc();
        cur_stage = 1;
      end
      apply_vec(vecs[i]);
      #1;
      check($sformatf("t3_vec%0d_wr", i), {15'd0, mem_wr_en}, {15'd0, vecs[i].exp_w});
      check($sformatf("t3_vec%0d_addr", i), mem_address, vecs[i].exp_a);
      check($sformatf("t3_vec%0d_data", i), mem_data_out, vecs[i].exp_d);
      cyc();
    end
    sa_done = 1; sa_wr_en = 1; sa_address = 16'h0301;
    #1;
    check("t3_sa_write_with_done", {15'd0, mem_wr_en}, 16'd1);
    cyc();
    check("t3_finish_done", {15'd0, done}, 16'd1);
    check("t3_finish_no_wr", {15'd0, mem_wr_en}, 16'd0);
    check("t3_finish_addr_zero", mem_address, 16'd0);
    clear_clients();
    cyc();

    // watchdog expiry in SA_WAIT
    offer_pkt(16'h0011, 16'h0000, 16'h0000, 16'h0000);
    cyc();
    pkt_valid = 0;
    cyc();
    lc_done = 1;
    cyc();
    check("t4_sa_en", {15'd0, sa_en}, 16'd1);
    lc_done = 0;
    for (int k = 0; k < 16; k++) cyc();
    check("t4_no_early_timeout", {14'd0, err, done}, 16'd0);
    cyc();
    check("t4_err_set", {15'd0, err}, 16'd1);
    check("t4_abort_done", {15'd0, done}, 16'd1);
    cyc();
    check("t4_idle_after_abort", {15'd0, pkt_ready}, 16'd1);
    check("t4_err_sticky", {15'd0, err}, 16'd1);

    // next accept clears err; done coincident with expiry wins
    offer_pkt(16'h0012, 16'h0000, 16'h0000, 16'h0000);
    cyc();
    check("t5_accept_clears_err", {15'd0, err}, 16'd0);
    pkt_valid = 0;
    for (int k = 0; k < 16; k++) cyc();
    lc_done = 1;
    cyc();
    check("t5_done_wins_sa_en", {15'd0, sa_en}, 16'd1);
    check("t5_done_wins_err", {15'd0, err}, 16'd0);
    lc_done = 0;
    cyc();
    sa_done = 1;
    cyc();
    check("t5_done", {15'd0, done}, 16'd1);
    sa_done = 0;
    cyc();

    // back-to-back with pkt_valid held high
    exp_q.push_back(16'h0021);
    exp_q.push_back(16'h0022);
    offer_pkt(16'h0021, 16'h0000, 16'h0000, 16'h0000);
    cyc();
    check("t6_p1_lc_en", {15'd0, lc_en}, 16'd1);
    check("t6_p1_fields", fsourceID, exp_q.pop_front());
    offer_pkt(16'h0022, 16'h0000, 16'h0000, 16'h0000);
    cyc();
    check("t6_busy_ignored", fsourceID, 16'h0021);
    lc_done = 1;
    cyc();
    lc_done = 0;
    cyc();
    sa_done = 1;
    wait_high("t6_p1_done", 3, 5);
    check("t6_finish_not_ready", {15'd0, pkt_ready}, 16'd0);
    check("t6_finish_fields_held", fsourceID, 16'h0021);
    sa_done = 0;
    cyc();
    check("t6_idle_ready", {15'd0, pkt_ready}, 16'd1);
    check("t6_idle_fields_held", fsourceID, 16'h0021);
    cyc();
    check("t6_p2_lc_en", {15'd0, lc_en}, 16'd1);
    check("t6_p2_fields", fsourceID, exp_q.pop_front());
    pkt_valid = 0;
`ifdef SCHED_STATS_EN
    check("t6_pkt_count", pkt_count, 16'd6);
    check("t6_reinit_count", reinit_count, 16'd1);
`endif

    // reset during LC_WAIT
    cyc();
    lc_wr_en = 1; lc_address = 16'h0555; lc_data_out = 16'h0066;
    #1;
    check("t7_lc_write_live", {15'd0, mem_wr_en}, 16'd1);
    nrst = 0;
    cyc();
    check("t7_rst_en", {13'd0, lc_en, ri_en, sa_en}, 16'd0);
    check("t7_rst_mem_wr", {15'd0, mem_wr_en}, 16'd0);
    check("t7_rst_mem_addr", mem_address, 16'd0);
    check("t7_rst_ready", {15'd0, pkt_ready}, 16'd1);
    check("t7_rst_done", {15'd0, done}, 16'd0);
    check("t7_rst_fields", fsourceID, 16'd0);
    check("t7_rst_pkt_count", pkt_count, 16'd0);
    nrst = 1;
    clear_clients();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
